// File: rtl/rnd_lfsr_responder_if.sv
// RND handshake bundle between the MU0 RND controller and the LFSR responder.
// master = controller (req/ack/seed), slave = responder (busy/valid/data).
interface rnd_lfsr_responder_if #(
  parameter int WIDTH = 16
);
  logic             rnd_req;
  logic             rnd_ack;
  logic             seed_we;
  logic [WIDTH-1:0] seed_data;
  logic             rnd_busy;
  logic             rnd_valid;
  logic [WIDTH-1:0] rnd_data;

  modport master (
    output rnd_req,
    output rnd_ack,
    output seed_we,
    output seed_data,
    input  rnd_busy,
    input  rnd_valid,
    input  rnd_data
  );

  modport slave (
    input  rnd_req,
    input  rnd_ack,
    input  seed_we,
    input  seed_data,
    output rnd_busy,
    output rnd_valid,
    output rnd_data
  );
endinterface

// File: rtl/rnd_lfsr_responder.sv
// RND responder: answers each request with a fresh Galois LFSR word.
// Ports: clk, rst (sync, active-high), bus (slave side of the RND bundle).
module rnd_lfsr_responder #(
  parameter int               WIDTH        = 16,
  parameter logic [WIDTH-1:0] TAPS         = 16'hB400,
  parameter logic [WIDTH-1:0] SEED_DEFAULT = 16'hACE1,
  parameter int               STEPS        = 4
) (
  input  logic clk,
  input  logic rst,
  rnd_lfsr_responder_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam logic [3:0] LAST = 4'(STEPS - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [3:0]       r_cnt;
  logic [3:0]       w_cnt_nxt;
  logic [WIDTH-1:0] r_lfsr;
  logic [WIDTH-1:0] w_lfsr_nxt;
  logic [WIDTH-1:0] w_seed;
  logic [WIDTH-1:0] w_base;
  logic [WIDTH-1:0] w_step;

  // Zero would lock the LFSR up, so it is replaced on load.
  assign w_seed = (bus.seed_data == '0)
                ? SEED_DEFAULT : bus.seed_data;

  // A seed written with the request is the first word stepped.
  assign w_base = (r_state == S_IDLE && bus.seed_we)
                ? w_seed : r_lfsr;

  assign w_step = (r_lfsr >> 1)
                ^ (r_lfsr[0] ? TAPS : '0);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_lfsr_nxt  = r_lfsr;
    case (r_state)
      S_IDLE: begin
        w_lfsr_nxt = w_base;
        if (bus.rnd_req) begin
          w_cnt_nxt   = 4'd0;
          w_state_nxt = S_SHIFT;
        end
      end
      S_SHIFT: begin
        w_lfsr_nxt = w_step;
        w_cnt_nxt  = r_cnt + 4'd1;
        if (r_cnt == LAST)
          w_state_nxt = S_READY;
      end
      S_READY: begin
        if (bus.rnd_ack)
          w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_lfsr  <= SEED_DEFAULT;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_lfsr  <= w_lfsr_nxt;
    end
  end

  assign bus.rnd_busy  = (r_state == S_SHIFT);
  assign bus.rnd_valid = (r_state == S_READY);
  assign bus.rnd_data  = r_lfsr;

endmodule

// File: doc/rnd_lfsr_responder.md
# rnd_lfsr_responder

Responder side of the MU0 RND instruction handshake. While the RND state machine is in its RND states, it issues a request. This block answers with a fresh 16-bit pseudo-random word from a maximal-length Galois LFSR. It holds `rnd_busy` high while the word is being produced, which the controller uses as its "extra cycle" qualifier, and presents the word on the data path until the controller acknowledges it.

## Interface
Parameters:
- `WIDTH`, 16: LFSR and data width; matches the MU0 word.
- `TAPS`, 16'hB400: Galois feedback mask, x^16+x^14+x^13+x^11+1, period 65535.
- `SEED_DEFAULT`, 16'hACE1: LFSR value after reset, and the substitute for an all-zero seed.
- `STEPS`, 4: LFSR shifts per request. Legal range 1..15.

Ports:
- `clk`, input, 1: single clock. All state changes on the rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `rnd_req`, input, 1: request from the RND state machine. Sampled only in IDLE.
- `rnd_ack`, input, 1: controller has consumed `rnd_data`. Sampled only in READY.
- `seed_we`, input, 1: load seed. Honoured only in IDLE.
- `seed_data`, input, WIDTH: seed value.
- `rnd_busy`, output, 1: high in SHIFT. Feeds the controller's extra-cycle input.
- `rnd_valid`, output, 1: high in READY.
- `rnd_data`, output, WIDTH: current LFSR register. Guaranteed stable only while `rnd_valid`=1.

## Operation
- State is a 2-bit encoding: IDLE=0, SHIFT=1, READY=2. Code 3 is illegal and returns to IDLE on the next edge.
- The step counter is 4 bits.
- One LFSR step is `lfsr <= (lfsr >> 1) ^ (lfsr[0] ? TAPS : 0)`.
- IDLE:
  - `seed_we`=1 loads `seed_data` into the LFSR.
  - If `seed_data`==0, the LFSR loads `SEED_DEFAULT` instead. The LFSR never holds zero.
  - `rnd_req`=1 sets the counter to 0 and moves to SHIFT.
  - If both are high in the same cycle, the seed loads and the request is also accepted. The first step then operates on the loaded seed.
- SHIFT:
  - Each edge performs one LFSR step and increments the counter.
  - On the edge that performs step number `STEPS`, the state moves to READY.
  - `rnd_req`, `rnd_ack` and `seed_we` are ignored.
- READY:
  - The LFSR holds.
  - `rnd_ack`=1 moves to IDLE. Otherwise the block stays in READY indefinitely with `rnd_data` held.
  - `rnd_req` and `seed_we` are ignored.
- The LFSR keeps its value across requests. Each request continues the same sequence.

## Timing
- Reset values: state=IDLE, counter=0, LFSR=`SEED_DEFAULT`. Hence `rnd_busy`=0, `rnd_valid`=0, `rnd_data`=16'hACE1.
- Reset has priority over every other input, in any state. A reset during SHIFT or READY discards the in-progress word and returns all outputs to their reset values on the next edge.
- Request latency:
  - `rnd_req` sampled at edge k.
  - `rnd_busy`=1 from edge k to edge k+`STEPS`.
  - `rnd_valid`=1 from edge k+`STEPS`.
  - With `STEPS`=4, valid appears 4 cycles after the request edge.
- Acknowledge:
  - `rnd_ack` sampled at edge m while in READY drops `rnd_valid` after edge m.
  - An ack raised in the same cycle `rnd_valid` first rises is honoured at the next edge. Valid is then high for exactly 1 cycle.
- Back-to-back requests:
  - After the ack edge the block is in IDLE for at least one cycle.
  - A `rnd_req` held high through the ack is accepted at the following edge.
  - Minimum request-to-request spacing is `STEPS`+2 edges.
- `rnd_busy` and `rnd_valid` are never high together. Both are decoded from registered state, with no combinational path from inputs.

## Test plan
- **Reset and first word:**
  - Stimulus: reset, then `rnd_req` pulse, `STEPS`=4.
  - Required: `rnd_busy` high for 4 cycles, then `rnd_valid`=1 with `rnd_data`=16'h1C4E.
  - Intermediate LFSR values: E270, 7138, 389C.
- **Second request without reseed:**
  - Stimulus: ack, then request again.
  - Required: sequence continues from 16'h1C4E; the result matches the reference model after 8 total steps from ACE1.
- **Zero seed:**
  - Stimulus: `seed_we`=1 with `seed_data`=0 in IDLE.
  - Required: LFSR=16'hACE1.
  - Stimulus: seed 16'h0001, then request.
  - Required: first step yields 16'hB400.
- **Ignored inputs:**
  - Stimulus: `seed_we` and `rnd_req` pulsed during SHIFT, and `seed_we` during READY.
  - Required: no change to the sequence or the latency.
- **Hold and ack timing:**
  - Stimulus: no ack for 10 cycles.
  - Required: `rnd_valid` and `rnd_data` stable throughout.
  - Stimulus: ack with `rnd_req` held high.
  - Required: exactly one IDLE cycle, then a new SHIFT.
- **Reset mid-operation:**
  - Stimulus: `rst` during the 2nd SHIFT cycle.
  - Required: next cycle `rnd_busy`=0, `rnd_valid`=0, `rnd_data`=16'hACE1; a following request reproduces 16'h1C4E.
